// File: rtl/alut_age_scheduler.sv
// alut_age_scheduler
// Sequences the ALUT age-check and flush scans. It owns the prescaled time
// base and walks every table entry through a shared synchronous-read memory
// port. Aged or flushed entries are invalidated. The port is handed over to
// the address checker whenever that checker is active.
//
// Ports:
//   pclk, n_p_reset      clock, asynchronous active-low reset
//   div_clk              prescaler terminal count (0 = tick every cycle)
//   best_bfr_age         age threshold; an entry is aged when its age is strictly greater
//   command              one-cycle pulse: 01 invalidate aged, 10 flush all
//   add_check_active     address checker owns the memory port this cycle
//   mem_rdata            read data, valid in the cycle after mem_re
//   mem_re/mem_we        read/write strobes
//   mem_addr/mem_wdata   entry index and write data; both hold between strobes
//   curr_time            free-running time base
//   age_check_active     scan in progress
//   inval_in_prog        invalidating write this cycle
//   lst_inv_addr_cmd     mac of the last entry the scan invalidated
//   lst_inv_port_cmd     port of the last entry the scan invalidated
module alut_age_scheduler #(
  parameter int unsigned NUM_ENTRIES = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             pclk,
  input  logic             n_p_reset,
  input  logic [7:0]       div_clk,
  input  logic [31:0]      best_bfr_age,
  input  logic [1:0]       command,
  input  logic             add_check_active,
  input  logic [82:0]      mem_rdata,
  output logic             mem_re,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [82:0]      mem_wdata,
  output logic [31:0]      curr_time,
  output logic             age_check_active,
  output logic             inval_in_prog,
  output logic [47:0]      lst_inv_addr_cmd,
  output logic [1:0]       lst_inv_port_cmd
);

  localparam int unsigned VALID_BIT = 82;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       pre_cnt;
  logic             tick;
  logic             flush_mode, flush_mode_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, addr_q;
  logic [82:0]      entry, entry_nxt, wdata_q;
  logic [31:0]      age;

  // Prescaler and time base
  assign tick = (pre_cnt == div_clk);

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      pre_cnt   <= 8'd0;
      curr_time <= 32'd0;
    end else begin
      pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
      if (tick) curr_time <= curr_time + 32'd1;
    end
  end

  // Modulo-2^32 difference, so a wrapped curr_time still yields the true age
  assign age = curr_time - mem_rdata[31:0];

  // State register and scan context
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      state      <= IDLE;
      idx        <= '0;
      flush_mode <= 1'b0;
      entry      <= 83'd0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      flush_mode <= flush_mode_nxt;
      entry      <= entry_nxt;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    flush_mode_nxt = flush_mode;
    entry_nxt      = entry;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    inval_in_prog  = 1'b0;
    unique case (state)
      IDLE: begin
        if (command == 2'b01 || command == 2'b10) begin
          flush_mode_nxt = command[1];
          idx_nxt        = '0;
          state_nxt      = READ;
        end
      end
      READ: begin
        if (!add_check_active) begin
          mem_re    = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        entry_nxt = mem_rdata;
        if (mem_rdata[VALID_BIT] && (flush_mode || age > best_bfr_age)) begin
          state_nxt = WRITE;
        end else if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = READ;
        end
      end
      WRITE: begin
        // The checker may rewrite this entry, so yield and re-read it
        if (add_check_active) begin
          state_nxt = READ;
        end else begin
          mem_we        = 1'b1;
          inval_in_prog = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = READ;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign age_check_active = (state != IDLE);

  // Address and write data follow the strobes and otherwise hold
  assign mem_addr  = (mem_re || mem_we) ? idx : addr_q;
  assign mem_wdata = mem_we ? {1'b0, entry[81:0]} : wdata_q;

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      addr_q           <= '0;
      wdata_q          <= 83'd0;
      lst_inv_addr_cmd <= 48'd0;
      lst_inv_port_cmd <= 2'd0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (mem_we) begin
        lst_inv_addr_cmd <= entry[79:32];
        lst_inv_port_cmd <= entry[81:80];
      end
    end
  end

endmodule

// File: tb/tb_alut_age_scheduler.sv
// Bench for alut_age_scheduler: a 4-entry memory environment, a time-base
// model and a table-level prediction of each scan's outcome.
module tb_alut_age_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          pclk = 1'b0;
  logic          n_p_reset = 1'b1;
  logic [7:0]    div_clk = 8'd0;
  logic [31:0]   best_bfr_age = 32'd0;
  logic [1:0]    command = 2'b00;
  logic          add_check_active = 1'b0;
  logic [82:0]   mem_rdata;
  logic          mem_re, mem_we;
  logic [IW-1:0] mem_addr;
  logic [82:0]   mem_wdata;
  logic [31:0]   curr_time;
  logic          age_check_active, inval_in_prog;
  logic [47:0]   lst_inv_addr_cmd;
  logic [1:0]    lst_inv_port_cmd;

  alut_age_scheduler #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
    .pclk(pclk), .n_p_reset(n_p_reset), .div_clk(div_clk),
    .best_bfr_age(best_bfr_age), .command(command),
    .add_check_active(add_check_active), .mem_rdata(mem_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .curr_time(curr_time),
    .age_check_active(age_check_active), .inval_in_prog(inval_in_prog),
    .lst_inv_addr_cmd(lst_inv_addr_cmd), .lst_inv_port_cmd(lst_inv_port_cmd)
  );

  always #5 pclk = ~pclk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_val(input string tag, input logic [82:0] act, input logic [82:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Synchronous-read table plus a host port standing in for the address checker
  logic [82:0]   mem [N];
  logic          hw_en = 1'b0;
  logic [IW-1:0] hw_addr = '0;
  logic [82:0]   hw_data = 83'd0;

  always @(posedge pclk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (hw_en)  mem[hw_addr] <= hw_data;
  end

  // Time base expectation: one tick after every div_clk+1 prescaler counts
  logic [7:0]  m_cnt;
  logic [31:0] m_time;
  always @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      m_cnt  <= 8'd0;
      m_time <= 32'd0;
    end else if (m_cnt == div_clk) begin
      m_cnt  <= 8'd0;
      m_time <= m_time + 32'd1;
    end else begin
      m_cnt <= m_cnt + 8'd1;
    end
  end

  // Per-cycle invariants
  int unsigned pulse_cnt = 0;
  always @(negedge pclk) begin
    if (n_p_reset) begin
      check_val("curr_time", 83'(curr_time), 83'(m_time));
      check_val("re_we_excl", 83'(mem_re & mem_we), 83'(0));
      check_val("strobe_vs_checker", 83'((mem_re | mem_we) & add_check_active), 83'(0));
      check_val("inval_eq_we", 83'(inval_in_prog), 83'(mem_we));
      if (inval_in_prog) pulse_cnt++;
    end
  end

  // Scan expectation state
  logic [82:0] tbl [N];
  logic [82:0] exp_tbl [N];
  int unsigned exp_inv;
  logic [47:0] m_mac;
  logic [1:0]  m_port;
  logic [82:0] m_wdata;

  function automatic logic [82:0] mk(input logic v, input logic [1:0] p,
                                     input logic [47:0] mac, input logic [31:0] ts);
    return {v, p, mac, ts};
  endfunction

  task automatic predict(input logic [31:0] t, input logic [31:0] age, input bit flush);
    logic [31:0] a;
    exp_inv = 0;
    for (int i = 0; i < N; i++) begin
      a = t - tbl[i][31:0];
      exp_tbl[i] = tbl[i];
      if (tbl[i][82] && (flush || a > age)) begin
        exp_tbl[i][82] = 1'b0;
        exp_inv++;
        m_mac   = tbl[i][79:32];
        m_port  = tbl[i][81:80];
        m_wdata = exp_tbl[i];
      end
    end
  endtask

  task automatic do_reset();
    n_p_reset = 1'b0;
    command = 2'b00;
    add_check_active = 1'b0;
    hw_en = 1'b0;
    m_mac = 48'd0;
    m_port = 2'd0;
    m_wdata = 83'd0;
    @(posedge pclk); #1;
    check_val("rst_time", 83'(curr_time), 83'(0));
    check_val("rst_active", 83'(age_check_active), 83'(0));
    check_val("rst_re_we", 83'({mem_re, mem_we, inval_in_prog}), 83'(0));
    check_val("rst_addr", 83'(mem_addr), 83'(0));
    check_val("rst_wdata", mem_wdata, 83'(0));
    check_val("rst_lst", 83'({lst_inv_port_cmd, lst_inv_addr_cmd}), 83'(0));
    n_p_reset = 1'b1;
  endtask

  // Bring curr_time to target, then freeze it for 256 cycles
  task automatic set_time(input logic [31:0] target);
    int guard = 0;
    div_clk = 8'd0;
    while (m_time != target && guard < 2000) begin
      @(posedge pclk); #1;
      guard++;
    end
    div_clk = 8'd255;
    check_val("time_preset", 83'(curr_time), 83'(target));
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      hw_en = 1'b1;
      hw_addr = IW'(i);
      hw_data = tbl[i];
      @(posedge pclk); #1;
    end
    hw_en = 1'b0;
  endtask

  // mode 0 clean, 1 random checker, 2 READ stall x5, 3 checker refreshes entry 0 in WRITE, 4 mid-scan command
  task automatic run_scan(input logic [1:0] cmd, input int mode,
                          input logic [31:0] t, input logic [31:0] age);
    int cyc = 0;
    int exp_cyc;
    best_bfr_age = age;
    predict(t, age, cmd == 2'b10);
    pulse_cnt = 0;
    command = cmd;
    @(posedge pclk); #1;
    command = 2'b00;
    check_val("start_latency", 83'(age_check_active), 83'(1));
    while (age_check_active && cyc < 400) begin
      cyc++;
      case (mode)
        1: add_check_active = ($urandom_range(0, 3) == 0);
        2: add_check_active = (cyc <= 5);
        3: begin
          add_check_active = (cyc == 3);
          hw_en = (cyc == 3);
          hw_addr = '0;
          hw_data = tbl[0];
        end
        4: command = (cyc == 4) ? 2'b10 : 2'b00;
        default: add_check_active = 1'b0;
      endcase
      @(posedge pclk); #1;
    end
    add_check_active = 1'b0;
    hw_en = 1'b0;
    command = 2'b00;
    check_val("scan_end", 83'(age_check_active), 83'(0));
    exp_cyc = 2 * N + exp_inv + 1 + ((mode == 2) ? 5 : 0) + ((mode == 3) ? 3 : 0);
    if (mode != 1) check_val("scan_cycles", 83'(cyc), 83'(exp_cyc));
    check_val("pulses", 83'(pulse_cnt), 83'(exp_inv));
    for (int i = 0; i < N; i++) check_val($sformatf("entry%0d", i), mem[i], exp_tbl[i]);
    check_val("lst_mac", 83'(lst_inv_addr_cmd), 83'(m_mac));
    check_val("lst_port", 83'(lst_inv_port_cmd), 83'(m_port));
    check_val("addr_hold", 83'(mem_addr), 83'(N - 1));
    check_val("wdata_hold", mem_wdata, m_wdata);
    @(posedge pclk); #1;
    check_val("stay_idle", 83'(age_check_active), 83'(0));
  endtask

  task automatic table_100();
    tbl[0] = mk(1'b1, 2'd1, 48'hA0A0_0000_0000, 32'd0);
    tbl[1] = mk(1'b1, 2'd2, 48'hA1A1_0000_0001, 32'd90);
    tbl[2] = mk(1'b1, 2'd3, 48'hA2A2_0000_0002, 32'd95);
    tbl[3] = mk(1'b1, 2'd0, 48'hA3A3_0000_0003, 32'd100);
  endtask

  initial begin
    logic [31:0] t;
    logic [1:0]  rc;
    int          rm;

    // Prescaler: div_clk = 3 ticks every 4th cycle
    div_clk = 8'd3;
    do_reset();
    repeat (8) @(posedge pclk);
    #1 check_val("div3_after8", 83'(curr_time), 83'(2));
    repeat (3) @(posedge pclk);
    #1 check_val("div3_after11", 83'(curr_time), 83'(2));
    @(posedge pclk);
    #1 check_val("div3_after12", 83'(curr_time), 83'(3));

    // Timestamp older than a small curr_time: age wraps modulo 2^32
    do_reset();
    set_time(32'd5);
    tbl[0] = mk(1'b1, 2'd1, 48'h1111_2222_3333, 32'hFFFF_FFF0);
    tbl[1] = mk(1'b1, 2'd2, 48'h4444_5555_6666, 32'h0000_0000);
    tbl[2] = mk(1'b0, 2'd3, 48'h7777_8888_9999, 32'hFFFF_FFF0);
    tbl[3] = mk(1'b1, 2'd0, 48'hAAAA_BBBB_CCCC, 32'hFFFF_FFF4);
    load_table();
    run_scan(2'b01, 0, 32'd5, 32'h10);
    tbl[0][82] = 1'b1;
    tbl[3][82] = 1'b1;
    load_table();
    run_scan(2'b01, 0, 32'd5, 32'hFFFF_FFFF);

    // Aged scan, flush, flush with an invalid entry
    set_time(32'd100);
    table_100();
    load_table();
    run_scan(2'b01, 0, 32'd100, 32'd8);
    table_100();
    load_table();
    run_scan(2'b10, 0, 32'd100, 32'd8);
    table_100();
    tbl[2][82] = 1'b0;
    load_table();
    run_scan(2'b10, 0, 32'd100, 32'd8);

    // Checker contention: READ stall, WRITE interference with a refresh, mid-scan command
    set_time(32'd300);
    table_100();
    for (int i = 0; i < N; i++) tbl[i][31:0] = tbl[i][31:0] + 32'd200;
    load_table();
    run_scan(2'b01, 2, 32'd300, 32'd8);
    table_100();
    for (int i = 0; i < N; i++) tbl[i][31:0] = tbl[i][31:0] + 32'd200;
    load_table();
    tbl[0][31:0] = 32'd300;
    run_scan(2'b01, 3, 32'd300, 32'd8);
    table_100();
    for (int i = 0; i < N; i++) tbl[i][31:0] = tbl[i][31:0] + 32'd200;
    load_table();
    run_scan(2'b01, 4, 32'd300, 32'd8);

    // Reset while a write is pending: scan aborts, entry untouched
    set_time(32'd400);
    table_100();
    for (int i = 0; i < N; i++) tbl[i][31:0] = tbl[i][31:0] + 32'd300;
    load_table();
    best_bfr_age = 32'd8;
    command = 2'b01;
    @(posedge pclk); #1;
    command = 2'b00;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check_val("write_pending", 83'(mem_we), 83'(1));
    n_p_reset = 1'b0;
    #1;
    check_val("abort_active", 83'(age_check_active), 83'(0));
    check_val("abort_we", 83'(mem_we | inval_in_prog), 83'(0));
    @(posedge pclk); #1;
    check_val("abort_entry0", mem[0], tbl[0]);
    check_val("abort_lst", 83'(lst_inv_addr_cmd), 83'(0));
    do_reset();

    // Randomized scans
    for (int it = 0; it < 24; it++) begin
      t = m_time + 32'($urandom_range(1, 60));
      set_time(t);
      for (int i = 0; i < N; i++) begin
        tbl[i] = mk($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    {16'($urandom), 32'($urandom)},
                    ($urandom_range(0, 3) == 0) ? 32'($urandom) : t - 32'($urandom_range(0, 30)));
      end
      load_table();
      rc = 2'($urandom_range(0, 3));
      rm = $urandom_range(0, 1);
      if (rc == 2'b01 || rc == 2'b10) begin
        run_scan(rc, rm, t, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 30)));
      end else begin
        command = rc;
        @(posedge pclk); #1;
        command = 2'b00;
        repeat (3) begin
          check_val("ignored_cmd", 83'(age_check_active), 83'(0));
          @(posedge pclk); #1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alut_age_scheduler.md
Name: alut_age_scheduler

Overview:
- Sequences the ALUT age-check and flush operations requested through the register-bank command field.
- Owns the free-running time base (curr_time), prescaled by div_clk.
- Walks every table entry through a shared synchronous-read memory port, invalidating entries older than best_bfr_age (or all entries on flush).
- Yields the memory port to the address checker whenever that checker is active. Reports status and last-invalidated entry to the register bank.

Parameters:
NUM_ENTRIES, 256, table depth (power of 2, minimum 2)
IDX_W, 8, table index width, log2(NUM_ENTRIES)

Ports:
pclk  in  1  clock
n_p_reset  in  1  asynchronous active-low reset
div_clk  in  8  prescaler terminal count
best_bfr_age  in  32  age threshold
command  in  2  one-cycle pulse: 00 none, 01 invalidate aged, 10 flush all, 11 reserved
add_check_active  in  1  address checker owns memory this cycle
mem_rdata  in  83  entry read data: [82] valid, [81:80] port, [79:32] mac, [31:0] timestamp
mem_re  out  1  read strobe
mem_we  out  1  write strobe
mem_addr  out  IDX_W  entry index
mem_wdata  out  83  write data
curr_time  out  32  time base
age_check_active  out  1  scan in progress
inval_in_prog  out  1  invalidating write this cycle
lst_inv_addr_cmd  out  48  mac of last entry invalidated by scan
lst_inv_port_cmd  out  2  port of last entry invalidated by scan

Behaviour:
- Reset: all outputs and internal registers clear to 0, FSM goes to IDLE, memory is untouched.
- Reset mid-scan aborts immediately; no partial write is issued after reset.
- Prescaler: an 8-bit count increments each cycle.
  - When count == div_clk, a tick fires and count returns to 0.
  - div_clk = 0 gives a tick every cycle.
  - A div_clk change takes effect at the next compare.
- curr_time increments on each tick and wraps 0xFFFF_FFFF -> 0.
- FSM states: IDLE, READ, CHECK, WRITE, DONE.
  - IDLE: command 01 or 10 latches mode, sets idx = 0, goes to READ. Command 11 or 00 is ignored.
  - Commands arriving outside IDLE are dropped.
  - READ: if add_check_active, stall with no strobe. Otherwise assert mem_re with mem_addr = idx and go to CHECK.
  - CHECK: mem_rdata is valid this cycle; capture it.
    - Compute age = curr_time - timestamp, modulo 2^32, so a wrapped curr_time is handled.
    - Invalidate if valid = 1 and (mode = flush, or age > best_bfr_age strictly). If so, go to WRITE.
    - Otherwise, if idx = NUM_ENTRIES-1 go to DONE; else increment idx and go to READ.
  - WRITE: if add_check_active, go back to READ with the same idx. The entry is re-read because the checker may have modified it.
    - Otherwise assert mem_we with mem_addr = idx and mem_wdata = captured entry with bit 82 cleared.
    - In the same cycle assert inval_in_prog and load lst_inv_addr_cmd/lst_inv_port_cmd from the captured entry (registered, visible next cycle).
    - Then advance exactly as CHECK does.
  - DONE: one cycle, then IDLE.
- age_check_active = 1 in READ, CHECK, WRITE and DONE.
- mem_re and mem_we are never both high, and neither is high while add_check_active = 1.
- mem_addr and mem_wdata hold their last value when no strobe is asserted.
- best_bfr_age = 0xFFFF_FFFF means aged mode never invalidates.
- Latency with no contention: command to age_check_active high is 1 cycle. A scan takes 2*NUM_ENTRIES + (number of invalidations) + 1 cycles.
- Wrap-around: idx never wraps. The scan terminates after entry NUM_ENTRIES-1.

Test Plan:
- Reset, div_clk = 3 -> curr_time increments every 4th cycle. curr_time preset near 0xFFFF_FFFF -> wraps to 0 and continues.
- NUM_ENTRIES = 4; timestamps 0, 90, 95, 100 (all valid); curr_time = 100; best_bfr_age = 8; command 01 -> entries 0 and 1 invalidated. Final lst_inv_addr_cmd = mac of entry 1. Scan takes 11 cycles.
- Same table with command 10 -> all 4 valid entries cleared, 4 inval_in_prog pulses. An invalid entry is neither written nor pulsed.
- add_check_active held high for 5 cycles while in READ -> no strobes and the scan resumes at the same idx. add_check_active raised while in WRITE -> entry is re-read, and if the checker refreshed its timestamp it is not invalidated.
- curr_time = 0x0000_0005, timestamp 0xFFFF_FFF0, best_bfr_age = 0x10 -> age = 0x15, entry invalidated. best_bfr_age = 0xFFFF_FFFF -> no invalidation.
- Command pulse mid-scan -> ignored. Reset asserted during WRITE wait -> age_check_active = 0 immediately and no write is issued.
